data_memory_ctrl: RTL and testbench

- Parametrised, vendor-neutral data memory for the Kabeta core. It is the successor to the fixed 16 KB block-RAM data memory.
- Inferred synchronous RAM of configurable width and depth. Supports byte-lane write masks, a valid/ready request handshake, a one-cycle registered read response and out-of-range detection.
- Sits between the MEM pipeline stage and on-chip RAM. Optionally zero-fills itself after reset.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_ram_be.sv | 32 +++
 rtl/data_memory_ctrl.sv | 135 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, defaults and the byte-lane mask helper for the Kabeta data memory.
package dmem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dmem_state_t;

    localparam int DMEM_DATA_W_DEF = 32;
    localparam int DMEM_DEPTH_DEF  = 4096;

    // Widest word the lane helper supports; callers cast the result down to DATA_W.
    localparam int DMEM_MAX_DATA_W = 1024;
    localparam int DMEM_MAX_BE_W   = DMEM_MAX_DATA_W / 8;

    function automatic logic [DMEM_MAX_DATA_W-1:0] lane_mask(input logic [DMEM_MAX_BE_W-1:0] be);
        logic [DMEM_MAX_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DMEM_MAX_BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// Byte-enabled single-port synchronous RAM; the array has no reset so it maps onto block RAM.
module dmem_ram_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = 12,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Kabeta data memory: request handshake, range check and registered responses around dmem_ram_be.
// Define DMEM_INIT_ZERO_EN to zero-fill the array after every reset before accepting requests.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W_DEF,
    parameter int DEPTH  = DMEM_DEPTH_DEF,
    parameter int ADDR_W = 30,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BE_W-1:0]   req_be,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              accept;
    logic              in_range;
    logic [DATA_W-1:0] lane_bits;
    logic              rsp_rd_q;

    logic              ram_we;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_addr;
    logic [BE_W-1:0]   ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign accept    = req_valid & req_ready;
    // Full-width compare so an aliasing upper address bit can never hit a real word.
    assign in_range  = (req_addr < ADDR_W'(DEPTH));
    assign lane_bits = DATA_W'(lane_mask(DMEM_MAX_BE_W'(req_be)));

`ifdef DMEM_INIT_ZERO_EN
    dmem_state_t      state;
    logic [IDX_W-1:0] init_cnt;

    // Ready follows RUN by one edge so the last zero write has landed before service starts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == IDX_W'(DEPTH - 1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    req_ready <= 1'b1;
                    init_done <= 1'b1;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        ram_we    = accept & req_write & in_range;
        ram_re    = accept & ~req_write & in_range;
        ram_addr  = req_addr[IDX_W-1:0];
        ram_be    = req_be;
        ram_wdata = req_data & lane_bits;
        if (state == ST_INIT) begin
            ram_we    = 1'b1;
            ram_re    = 1'b0;
            ram_addr  = init_cnt;
            ram_be    = '1;
            ram_wdata = '0;
        end
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            req_ready <= 1'b1;
            init_done <= 1'b1;
        end
    end

    always_comb begin
        ram_we    = accept & req_write & in_range;
        ram_re    = accept & ~req_write & in_range;
        ram_addr  = req_addr[IDX_W-1:0];
        ram_be    = req_be;
        ram_wdata = req_data & lane_bits;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rd_q  <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept & ~in_range;
            rsp_rd_q  <= accept & ~req_write & in_range;
        end
    end

    // RAM output register only drives the bus for in-range reads.
    assign rsp_data = rsp_rd_q ? ram_rdata : '0;

    dmem_ram_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clock  (clock),
        .we     (ram_we),
        .re     (ram_re),
        .addr   (ram_addr),
        .be     (ram_be),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl (DEPTH=12); follows DMEM_INIT_ZERO_EN if defined.
module tb_data_memory_ctrl;

    localparam int DEPTH = 12;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [29:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    // Reference model: per-byte contents and whether each byte holds a defined value.
    logic [7:0] mb [DEPTH][4];
    bit         kn [DEPTH][4];
    bit         mdl_ready = 1'b0;

    typedef struct {
        logic        v;
        logic        w;
        logic [29:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic        exp_v;
        logic        exp_e;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl [18];

    data_memory_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(30)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, w, input logic [29:0] a, input logic [3:0] be,
                                input logic [31:0] d, input logic ev, ee, input logic [31:0] ed);
        vec_t r;
        r.v = v; r.w = w; r.a = a; r.be = be; r.d = d;
        r.exp_v = ev; r.exp_e = ee; r.exp_d = ed;
        return r;
    endfunction

    task automatic model_reset();
`ifdef DMEM_INIT_ZERO_EN
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < 4; j++) begin
                mb[i][j] = 8'h00;
                kn[i][j] = 1'b1;
            end
`endif
        mdl_ready = 1'b0;
    endtask

    // Drive one cycle at the negedge, update the model, sample the response at the next negedge.
    task automatic step(input logic v, w, input logic [29:0] a, input logic [3:0] be,
                        input logic [31:0] d, output logic ev, ee, output logic [31:0] ed, em);
        bit acc, oor;
        req_valid = v; req_write = w; req_addr = a; req_be = be; req_data = d;
        acc = v && mdl_ready;
        oor = (a >= 30'(DEPTH));
        ev = acc;
        ee = acc && oor;
        ed = '0;
        em = '1;
        if (acc && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (w) begin
                    if (be[i]) begin
                        mb[a][i] = d[8*i +: 8];
                        kn[a][i] = 1'b1;
                    end
                end else begin
                    ed[8*i +: 8] = mb[a][i];
                    em[8*i +: 8] = kn[a][i] ? 8'hFF : 8'h00;
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic compare(input string nm, input logic ev, ee, input logic [31:0] ed, em);
        check({nm, "_valid"}, 64'(rsp_valid), 64'(ev));
        check({nm, "_err"}, 64'(rsp_err), 64'(ee));
        if (em != 32'h0)
            check({nm, "_data"}, 64'(rsp_data & em), 64'(ed & em));
    endtask

    // Assumes reset was released since the last clock edge.
    task automatic wait_ready(input string nm);
        int  cnt;
        bit  seen_rsp;
        cnt = 0;
        seen_rsp = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_be = 4'hF; req_data = '0;
        while (cnt < 100) begin
            @(posedge clock);
            cnt++;
            @(negedge clock);
            if (rsp_valid === 1'b1) seen_rsp = 1'b1;
            if (req_ready === 1'b1) break;
        end
        req_valid = 1'b0;
`ifdef DMEM_INIT_ZERO_EN
        check({nm, "_ready_latency"}, 64'(cnt), 64'(DEPTH + 1));
`else
        check({nm, "_ready_latency"}, 64'(cnt), 64'd1);
`endif
        check({nm, "_init_done"}, 64'(init_done), 64'd1);
        check({nm, "_held_req_ignored"}, 64'(seen_rsp), 64'd0);
        mdl_ready = 1'b1;
    endtask

    initial begin
        logic        ev, ee;
        logic [31:0] ed, em;
        logic [29:0] ra;

        reset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_be = '0; req_data = '0;
        model_reset();
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        wait_ready("boot");

`ifdef DMEM_INIT_ZERO_EN
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 30'(i), 4'hF, 32'h0, ev, ee, ed, em);
            compare("zero_read", 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF);
        end
`endif

        tbl[0]  = mk(1, 1, 30'd5,  4'hF, 32'hDEADBEEF, 1, 0, 32'h0);
        tbl[1]  = mk(1, 1, 30'd5,  4'h1, 32'h000000AA, 1, 0, 32'h0);
        tbl[2]  = mk(1, 0, 30'd5,  4'h0, 32'h0,        1, 0, 32'hDEADBEAA);
        tbl[3]  = mk(1, 1, 30'd3,  4'hF, 32'h12345678, 1, 0, 32'h0);
        tbl[4]  = mk(1, 0, 30'd3,  4'hF, 32'h0,        1, 0, 32'h12345678);
        tbl[5]  = mk(1, 1, 30'd11, 4'hF, 32'hA5A5A5A5, 1, 0, 32'h0);
        tbl[6]  = mk(1, 1, 30'd12, 4'hF, 32'h55555555, 1, 1, 32'h0);
        tbl[7]  = mk(1, 0, 30'd12, 4'hF, 32'h0,        1, 1, 32'h0);
        tbl[8]  = mk(1, 0, 30'd11, 4'hF, 32'h0,        1, 0, 32'hA5A5A5A5);
        tbl[9]  = mk(0, 0, 30'd5,  4'hF, 32'h0,        0, 0, 32'h0);
        tbl[10] = mk(1, 1, 30'h20000005, 4'hF, 32'hFFFFFFFF, 1, 1, 32'h0);
        tbl[11] = mk(1, 0, 30'd5,  4'hF, 32'h0,        1, 0, 32'hDEADBEAA);
        tbl[12] = mk(1, 1, 30'd5,  4'h0, 32'h0,        1, 0, 32'h0);
        tbl[13] = mk(1, 0, 30'd5,  4'hF, 32'h0,        1, 0, 32'hDEADBEAA);
        tbl[14] = mk(1, 1, 30'd5,  4'h6, 32'h11223344, 1, 0, 32'h0);
        tbl[15] = mk(1, 0, 30'd5,  4'hF, 32'h0,        1, 0, 32'hDE2233AA);
        tbl[16] = mk(1, 1, 30'd0,  4'hF, 32'hCAFEF00D, 1, 0, 32'h0);
        tbl[17] = mk(1, 0, 30'd0,  4'hF, 32'h0,        1, 0, 32'hCAFEF00D);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].be, tbl[i].d, ev, ee, ed, em);
            compare($sformatf("vec%0d", i), tbl[i].exp_v, tbl[i].exp_e, tbl[i].exp_d, 32'hFFFFFFFF);
        end

        for (int i = 0; i < 300; i++) begin
            ra = 30'($urandom_range(0, DEPTH + 3));
            if ($urandom_range(0, 7) == 0) ra = 30'($urandom) | 30'h100;
            step($urandom_range(0, 3) != 0, 1'($urandom), ra, 4'($urandom), $urandom, ev, ee, ed, em);
            compare($sformatf("rnd%0d", i), ev, ee, ed, em);
        end

        // Reset pulse straddling the edge that would accept a read.
        step(1'b1, 1'b1, 30'd7, 4'hF, 32'h0BADF00D, ev, ee, ed, em);
        compare("pre_rst_wr", ev, ee, ed, em);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 30'd7; req_be = 4'hF;
        #3 reset_n = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("rst_drop_valid", 64'(rsp_valid), 64'd0);
        check("rst_drop_data", 64'(rsp_data), 64'd0);
        model_reset();
        wait_ready("rerun");
        step(1'b1, 1'b0, 30'd7, 4'hF, 32'h0, ev, ee, ed, em);
        compare("post_rst_rd7", ev, ee, ed, em);
        step(1'b1, 1'b0, 30'd5, 4'hF, 32'h0, ev, ee, ed, em);
        compare("post_rst_rd5", ev, ee, ed, em);
        step(1'b1, 1'b1, 30'd0, 4'hF, 32'hCAFEF00D, ev, ee, ed, em);
        compare("post_rst_wr0", ev, ee, ed, em);
        step(1'b1, 1'b0, 30'd0, 4'hF, 32'h0, ev, ee, ed, em);
        compare("post_rst_rd0", 1'b1, 1'b0, 32'hCAFEF00D, 32'hFFFFFFFF);
        step(1'b0, 1'b0, 30'd0, 4'h0, 32'h0, ev, ee, ed, em);
        compare("idle", 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
